// File: rtl/pwm_cap.sv
// PWM capture unit: measures period and high time of an asynchronous PWM input
// in clk cycles and exposes the results through a small register slave.
module pwm_cap #(
    parameter int cnt_width = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic        pwm_in,
    output logic        irq
);

    localparam logic [cnt_width-1:0] cnt_max = '1;
    localparam logic [cnt_width-1:0] cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    state_t state;
    state_t state_next;

    logic s1;
    logic s2;
    logic s3;
    logic level;
    logic rise;

    logic en;
    logic ie;
    logic valid;
    logic ovf;
    logic overrun;

    logic [cnt_width-1:0] period;
    logic [cnt_width-1:0] high;
    logic [cnt_width-1:0] pcnt;
    logic [cnt_width-1:0] hcnt;
    logic [cnt_width-1:0] pcnt_next;
    logic [cnt_width-1:0] hcnt_next;
    logic [cnt_width-1:0] pcnt_inc;
    logic [cnt_width-1:0] hcnt_inc;

    logic       capture;
    logic       ovf_set;
    logic       cr_sel;
    logic       st_sel;
    logic [2:0] clr;

    // Only addr[3:0] and the low data bits carry meaning.
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], wd[31:3]};

    assign level = s2;
    assign rise  = s2 & ~s3;

    assign cr_sel = we && (addr[3:0] == 4'h0);
    assign st_sel = we && (addr[3:0] == 4'h4);
    assign clr    = st_sel ? wd[2:0] : 3'b000;

    assign pcnt_inc = (pcnt == cnt_max) ? cnt_max : pcnt + cnt_one;
    assign hcnt_inc = (hcnt == cnt_max || !level) ? hcnt : hcnt + cnt_one;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pcnt  <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_next;
            pcnt  <= pcnt_next;
            hcnt  <= hcnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pcnt_next  = '0;
        hcnt_next  = '0;
        capture    = 1'b0;
        ovf_set    = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: state_next = ARM;
                ARM: begin
                    if (rise) begin
                        state_next = MEAS;
                        hcnt_next  = cnt_one;
                    end
                end
                MEAS: begin
                    ovf_set = (pcnt == cnt_max);
                    if (rise) begin
                        capture   = 1'b1;
                        hcnt_next = cnt_one;
                    end else begin
                        pcnt_next = pcnt_inc;
                        hcnt_next = hcnt_inc;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: every register here, results included, is cleared by reset; nothing
    // observable is left undefined after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            valid   <= 1'b0;
            ovf     <= 1'b0;
            overrun <= 1'b0;
            period  <= '0;
            high    <= '0;
        end else begin
            if (cr_sel) begin
                en <= wd[0];
                ie <= wd[1];
            end
            // Set terms are OR-ed after the clear so a same-cycle set wins.
            valid   <= (valid   & ~clr[0]) | capture;
            ovf     <= (ovf     & ~clr[1]) | ovf_set;
            overrun <= (overrun & ~clr[2]) | (capture & valid);
            if (capture) begin
                period <= pcnt_inc;
                high   <= hcnt;
            end
        end
    end

    always_comb begin
        rd = '0;
        unique case (addr[3:0])
            4'h0:    rd[1:0] = {ie, en};
            4'h4:    rd[2:0] = {overrun, ovf, valid};
            4'h8:    rd[cnt_width-1:0] = period;
            4'hC:    rd[cnt_width-1:0] = high;
            default: rd = '0;
        endcase
    end

    assign irq = valid & ie;

endmodule

// File: tb/tb_pwm_cap.sv
// Self-checking bench for pwm_cap: a timestamp-based model checked every cycle,
// plus directed scenarios with hand-computed register values.
module tb_pwm_cap;

    localparam int CW    = 8;
    localparam int MAXV  = (1 << CW) - 1;
    localparam int W_PER = 10;
    localparam int W_HI  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        pwm_in;
    logic        irq;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  started     = 0;
    bit  wave_on     = 0;

    pwm_cap #(.cnt_width(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .wd     (wd),
        .rd     (rd),
        .pwm_in (pwm_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The input is seen two edges late; a rise is a 0->1 step of that view.
    // Period and high time come from rise timestamps and a count of high cycles.
    typedef enum int {M_IDLE, M_ARM, M_MEAS} mmode_t;
    mmode_t m_mode = M_IDLE;
    bit  hist[3];
    int  cyc = 0;
    int  last_rise = 0;
    int  hc = 0;
    bit  m_en = 0, m_ie = 0, m_valid = 0, m_ovf = 0, m_over = 0;
    int  m_period = 0, m_high = 0;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk) begin
        bit lvl, rs, sv, so, sr;
        logic [2:0] cl;
        if (reset) begin
            m_mode = M_IDLE;
            hist[0] = 0; hist[1] = 0; hist[2] = 0;
            m_en = 0; m_ie = 0; m_valid = 0; m_ovf = 0; m_over = 0;
            m_period = 0; m_high = 0; hc = 0; last_rise = 0;
        end else begin
            lvl = hist[1];
            rs  = hist[1] && !hist[2];
            sv = 0; so = 0; sr = 0;
            if (!m_en) m_mode = M_IDLE;
            else begin
                case (m_mode)
                    M_IDLE: m_mode = M_ARM;
                    M_ARM: if (rs) begin
                        m_mode = M_MEAS; last_rise = cyc; hc = 1;
                    end
                    M_MEAS: begin
                        if (cyc - last_rise >= MAXV + 1) so = 1;
                        if (rs) begin
                            m_period = min_i(cyc - last_rise, MAXV);
                            m_high   = min_i(hc, MAXV);
                            sv = 1; sr = m_valid;
                            last_rise = cyc; hc = 1;
                        end else hc += int'(lvl);
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
            cl = 3'b000;
            if (we && addr[3:0] == 4'h0) begin m_en = wd[0]; m_ie = wd[1]; end
            if (we && addr[3:0] == 4'h4) cl = wd[2:0];
            m_valid = (m_valid && !cl[0]) || sv;
            m_ovf   = (m_ovf   && !cl[1]) || so;
            m_over  = (m_over  && !cl[2]) || sr;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pwm_in;
        end
        cyc++;
    end

    initial begin
        @(posedge clk);
        #1 started = 1;
    end

    // Compare process: rd at the currently driven address and irq, every cycle.
    initial begin
        logic [31:0] e;
        wait (started);
        forever begin
            @(negedge clk);
            #1;
            case (addr[3:0])
                4'h0:    e = {30'b0, m_ie, m_en};
                4'h4:    e = {29'b0, m_over, m_ovf, m_valid};
                4'h8:    e = m_period;
                4'hC:    e = m_high;
                default: e = 32'h0;
            endcase
            check("model_rd", rd, e);
            check("model_irq", {31'b0, irq}, {31'b0, m_valid && m_ie});
        end
    end

    // PWM source: changes well after the active edge.
    initial begin
        int phase = 0;
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (wave_on) begin
                pwm_in = (phase < W_HI);
                phase  = (phase + 1) % W_PER;
            end else begin
                pwm_in = 1'b0;
                phase  = 0;
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wd = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; wd = '0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a;
        #2;
        check(name, rd, exp);
    endtask

    initial begin
        bit found;
        reset = 1'b1; addr = '0; we = 1'b0; wd = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus_read("rst_cr", 32'h0, 32'h0);
        bus_read("rst_status", 32'h4, 32'h0);
        bus_read("rst_period", 32'h8, 32'h0);
        bus_read("rst_high", 32'hC, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // 1) basic measurement, 10-cycle period, 3-cycle high
        bus_write(32'h0, 32'h1);
        wave_on = 1;
        repeat (18) @(negedge clk);
        bus_read("t1_period", 32'h8, 32'd10);
        bus_read("t1_high", 32'hC, 32'd3);
        bus_read("t1_status", 32'h4, 32'h1);
        wave_on = 0;
        check("t1_irq_masked", {31'b0, irq}, 32'h0);
        bus_read("t1_unmapped", 32'h1, 32'h0);
        bus_write(32'h0, 32'h0);
        bus_write(32'h4, 32'h7);

        // 2) interrupt and W1C
        bus_write(32'h0, 32'h3);
        wave_on = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #2;
            if (irq) found = 1;
        end
        check("t2_irq_seen", {31'b0, found}, 32'h1);
        wave_on = 0;
        bus_write(32'h4, 32'h1);
        bus_read("t2_status_clr", 32'h4, 32'h0);
        check("t2_irq_clr", {31'b0, irq}, 32'h0);
        bus_write(32'h0, 32'h0);

        // 3) overflow: one pulse, then low for 300 cycles
        bus_write(32'h0, 32'h1);
        wave_on = 1;
        repeat (6) @(negedge clk);
        wave_on = 0;
        repeat (300) @(negedge clk);
        bus_read("t3_ovf", 32'h4, 32'h2);
        wave_on = 1;
        repeat (7) @(negedge clk);
        wave_on = 0;
        bus_read("t3_status", 32'h4, 32'h3);
        bus_read("t3_period_sat", 32'h8, MAXV);
        bus_read("t3_high", 32'hC, 32'd3);
        bus_write(32'h4, 32'h7);
        bus_write(32'h0, 32'h0);

        // 4) overrun after two captures
        bus_write(32'h0, 32'h1);
        wave_on = 1;
        repeat (28) @(negedge clk);
        wave_on = 0;
        bus_read("t4_overrun", 32'h4, 32'h5);
        bus_write(32'h4, 32'h4);
        bus_read("t4_w1c", 32'h4, 32'h1);
        bus_read("t4_period_hiaddr", 32'hABCD_0008, 32'd10);
        bus_write(32'h4, 32'h7);
        bus_write(32'h0, 32'h0);

        // 5) clear colliding with capture, then disable mid-measurement
        bus_write(32'h0, 32'h1);
        wave_on = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (m_mode == M_MEAS && m_en && hist[1] && !hist[2]) begin
                addr = 32'h4; wd = 32'h1; we = 1'b1; found = 1;
            end
        end
        @(negedge clk);
        we = 1'b0; wd = '0;
        check("t5_collide_hit", {31'b0, found}, 32'h1);
        bus_read("t5_set_wins", 32'h4, 32'h1);
        bus_write(32'h0, 32'h0);
        bus_write(32'h4, 32'h7);
        repeat (30) @(negedge clk);
        bus_read("t5_idle_status", 32'h4, 32'h0);
        bus_read("t5_period_kept", 32'h8, 32'd10);

        // 6) reset during the high phase, then re-enable
        bus_write(32'h0, 32'h1);
        repeat (16) @(negedge clk);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pwm_in) found = 1;
        end
        check("t6_high_phase", {31'b0, found}, 32'h1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        bus_read("t6_cr", 32'h0, 32'h0);
        bus_read("t6_status", 32'h4, 32'h0);
        bus_read("t6_period", 32'h8, 32'h0);
        bus_read("t6_high", 32'hC, 32'h0);
        check("t6_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        bus_write(32'h0, 32'h1);
        repeat (6) @(negedge clk);
        bus_read("t6_first_rise", 32'h4, 32'h0);
        repeat (25) @(negedge clk);
        bus_read("t6_period_new", 32'h8, 32'd10);
        wave_on = 0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
